// File: rtl/freq_gate_ctrl_if.sv
// Handshake/result bundle between the frequency-meter sequencer and its
// surroundings: run request, counter-chain taps, gate controls and held result.
interface freq_gate_ctrl_if #(
  parameter int DIG_WIDTH = 8
);
  logic                     run_i;
  logic [DIG_WIDTH*4-1:0]   count_i;
  logic                     cout_i;
  logic                     cnt_rst_o;
  logic                     enable_o;
  logic [DIG_WIDTH*4-1:0]   freq_o;
  logic                     overflow_o;
  logic                     valid_o;
  logic                     busy_o;

  modport master (
    output run_i, count_i, cout_i,
    input  cnt_rst_o, enable_o, freq_o, overflow_o, valid_o, busy_o
  );

  modport slave (
    input  run_i, count_i, cout_i,
    output cnt_rst_o, enable_o, freq_o, overflow_o, valid_o, busy_o
  );
endinterface

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer: clears and gates the BCD decade counter chain, then
// latches its settled count and a synchronised overflow carry into clk domain.
module freq_gate_ctrl #(
  parameter int DIG_WIDTH     = 8,
  parameter int GATE_CYCLES   = 50000000,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  freq_gate_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATE,
    S_SETTLE,
    S_LATCH
  } state_e;

  localparam int MAX_CS = (CLEAR_CYCLES > SETTLE_CYCLES) ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int MAX_PH = (GATE_CYCLES > MAX_CS) ? GATE_CYCLES : MAX_CS;
  localparam int PH_W   = $clog2(MAX_PH) + 1;

  localparam logic [PH_W-1:0] CLEAR_LAST  = PH_W'(CLEAR_CYCLES - 1);
  localparam logic [PH_W-1:0] GATE_LAST   = PH_W'(GATE_CYCLES - 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic                   sticky_q, sticky_d;
  logic                   cout_meta_q, cout_sync_q, cout_prev_q;
  logic                   cnt_rst_q, enable_q, valid_q, busy_q, overflow_q;
  logic [DIG_WIDTH*4-1:0] freq_q;
  logic                   cout_rise;

  assign cout_rise = cout_sync_q & ~cout_prev_q;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    unique case (state_q)
      S_IDLE:   if (bus.run_i) state_d = S_CLEAR;
      S_CLEAR:  if (phase_q == CLEAR_LAST) state_d = S_GATE;
      S_GATE:   if (phase_q == GATE_LAST) state_d = S_SETTLE;
      S_SETTLE: if (phase_q == SETTLE_LAST) state_d = S_LATCH;
      S_LATCH:  state_d = bus.run_i ? S_CLEAR : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    phase_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : phase_q + PH_W'(1);

    // Carry edges only count while the gate is open or the chain is settling.
    if ((state_d == S_CLEAR) && (state_q != S_CLEAR)) begin
      sticky_d = 1'b0;
    end else if (cout_rise && ((state_q == S_GATE) || (state_q == S_SETTLE))) begin
      sticky_d = 1'b1;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      sticky_q    <= 1'b0;
      cout_meta_q <= 1'b0;
      cout_sync_q <= 1'b0;
      cout_prev_q <= 1'b0;
      cnt_rst_q   <= 1'b0;
      enable_q    <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      freq_q      <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sticky_q    <= sticky_d;
      cout_meta_q <= bus.cout_i;
      cout_sync_q <= cout_meta_q;
      cout_prev_q <= cout_sync_q;
      // Outputs are decoded from the next state so they line up with state_q.
      cnt_rst_q   <= (state_d == S_GATE) || (state_d == S_SETTLE) || (state_d == S_LATCH);
      enable_q    <= (state_d == S_GATE);
      busy_q      <= (state_d != S_IDLE);
      valid_q     <= (state_q == S_LATCH);
      // The chain has been frozen for SETTLE_CYCLES, so count_i is static here.
      if (state_q == S_LATCH) begin
        freq_q     <= bus.count_i;
        overflow_q <= sticky_q;
      end
    end
  end

  assign bus.cnt_rst_o  = cnt_rst_q;
  assign bus.enable_o   = enable_q;
  assign bus.freq_o     = freq_q;
  assign bus.overflow_o = overflow_q;
  assign bus.valid_o    = valid_q;
  assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: a BCD counter-chain model driven by
// the DUT's gate, with expected counts/overflow derived from injected stimulus.
module tb_freq_gate_ctrl;

  localparam int DW     = 4;
  localparam int GC     = 100;
  localparam int CC     = 4;
  localparam int SC     = 8;
  localparam int PERIOD = CC + GC + SC + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_gate_ctrl_if #(.DIG_WIDTH(DW)) bus ();

  freq_gate_ctrl #(
    .DIG_WIDTH(DW), .GATE_CYCLES(GC), .CLEAR_CYCLES(CC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int tgt   = 0;   // number of counts the chain sees during the next gate
  int gk    = 0;
  int digits[DW];

  // Counter chain: cleared while cnt_rst_o is low, spreads tgt increments
  // evenly over the enabled cycles, ripples as a decimal chain.
  always @(negedge clk) begin
    if (bus.cnt_rst_o !== 1'b1) begin
      for (int i = 0; i < DW; i++) digits[i] = 0;
      gk = 0;
    end else if (bus.enable_o === 1'b1) begin
      if (((gk + 1) * tgt) / GC > (gk * tgt) / GC) begin
        int c;
        c = 1;
        for (int i = 0; i < DW; i++) begin
          if (c == 1) begin
            if (digits[i] == 9) digits[i] = 0;
            else begin
              digits[i] = digits[i] + 1;
              c = 0;
            end
          end
        end
      end
      gk = gk + 1;
    end
    for (int i = 0; i < DW; i++) bus.count_i[i*4 +: 4] = 4'(digits[i]);
  end

  function automatic logic [DW*4-1:0] to_bcd(input int n);
    logic [DW*4-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int i = 0; i < DW; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Advance negedge by negedge until valid_o, within a cycle budget.
  task automatic wait_valid(input int budget, output bit got, output int waited,
                            output bit held);
    logic [DW*4-1:0] ref_f;
    ref_f  = bus.freq_o;
    got    = 1'b0;
    held   = 1'b1;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus.valid_o === 1'b1) got = 1'b1;
      else if (bus.freq_o !== ref_f) held = 1'b0;
    end
  endtask

  // One measurement starting at a valid_o negedge; kind 0 none, 1 carry in
  // GATE at negedge index pos, 2 carry during CLEAR.
  task automatic run_meas(input int t, input int kind, input int pos,
                          output bit got, output int span, output bit held);
    int w;
    int used;
    tgt  = t;
    used = 0;
    if (kind == 2) begin
      bus.cout_i = 1'b1;
      @(negedge clk);
      bus.cout_i = 1'b0;
      used = 1;
    end else if (kind == 1) begin
      repeat (pos - 1) @(negedge clk);
      bus.cout_i = 1'b1;
      @(negedge clk);
      bus.cout_i = 1'b0;
      used = pos;
    end
    wait_valid(PERIOD + 5, got, w, held);
    span = used + w;
  endtask

  task automatic test_reset();
    int  e_clr, e_gate, e_set, w;
    bit  got, held;
    rst        = 1'b0;
    bus.run_i  = 1'b1;
    bus.cout_i = 1'b0;
    tgt        = 25;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.cnt_rst_o, bus.enable_o, bus.freq_o, bus.overflow_o, bus.valid_o, bus.busy_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {bus.cnt_rst_o, bus.enable_o, bus.freq_o, bus.overflow_o, bus.valid_o, bus.busy_o});
    end
    rst = 1'b1;
    e_clr = 0; e_gate = 0; e_set = 0;
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (i <= CC) begin
        if (bus.cnt_rst_o !== 1'b0 || bus.enable_o !== 1'b0 || bus.busy_o !== 1'b1) e_clr++;
      end else if (i <= CC + GC) begin
        if (bus.cnt_rst_o !== 1'b1 || bus.enable_o !== 1'b1) e_gate++;
      end else begin
        if (bus.cnt_rst_o !== 1'b1 || bus.enable_o !== 1'b0 || bus.valid_o !== 1'b0) e_set++;
      end
    end
    total++;
    if (e_clr != 0) begin bad++; $display("FAIL clear_phase: got %0d bad cycles expected 0", e_clr); end
    total++;
    if (e_gate != 0) begin bad++; $display("FAIL gate_phase: got %0d bad cycles expected 0", e_gate); end
    total++;
    if (e_set != 0) begin bad++; $display("FAIL settle_latch_phase: got %0d bad cycles expected 0", e_set); end
    wait_valid(3, got, w, held);
    total++;
    if (!got || w != 1) begin
      bad++;
      $display("FAIL first_valid_timing: got valid=%0d after %0d expected 1 after 1", got, w);
    end
    total++;
    if (bus.freq_o !== to_bcd(25) || bus.overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL first_result: got %0h/%0b expected %0h/0", bus.freq_o, bus.overflow_o, to_bcd(25));
    end
  endtask

  task automatic test_continuous();
    int  seq[2] = '{26, 24};
    int  w;
    bit  got, held;
    foreach (seq[k]) begin
      tgt = seq[k];
      wait_valid(PERIOD + 5, got, w, held);
      total++;
      if (!got || w != PERIOD || !held) begin
        bad++;
        $display("FAIL cont_spacing_%0d: got valid=%0d gap=%0d held=%0d expected 1 gap=%0d held=1",
                 k, got, w, held, PERIOD);
      end
      total++;
      if (bus.freq_o !== to_bcd(seq[k]) || bus.overflow_o !== 1'b0) begin
        bad++;
        $display("FAIL cont_result_%0d: got %0h/%0b expected %0h/0",
                 k, bus.freq_o, bus.overflow_o, to_bcd(seq[k]));
      end
    end
  endtask

  task automatic test_overflow();
    int  kinds[3] = '{1, 0, 2};
    int  span;
    bit  got, held, exp_ovf;
    foreach (kinds[k]) begin
      exp_ovf = (kinds[k] == 1);
      run_meas(30 + k, kinds[k], 45, got, span, held);
      total++;
      if (!got || span != PERIOD) begin
        bad++;
        $display("FAIL ovf_timing_%0d: got valid=%0d span=%0d expected 1 span=%0d", k, got, span, PERIOD);
      end
      total++;
      if (bus.overflow_o !== exp_ovf || bus.freq_o !== to_bcd(30 + k)) begin
        bad++;
        $display("FAIL ovf_result_%0d: got %0b/%0h expected %0b/%0h",
                 k, bus.overflow_o, bus.freq_o, exp_ovf, to_bcd(30 + k));
      end
    end
  endtask

  task automatic test_random();
    int  t, kind, pos, span;
    bit  got, held, exp_ovf;
    for (int k = 0; k < 5; k++) begin
      t       = int'($urandom_range(0, GC));
      kind    = int'($urandom_range(0, 2));
      pos     = int'($urandom_range(5, 100));
      exp_ovf = (kind == 1);
      run_meas(t, kind, pos, got, span, held);
      total++;
      if (!got || span != PERIOD || bus.freq_o !== to_bcd(t) || bus.overflow_o !== exp_ovf) begin
        bad++;
        $display("FAIL random_%0d: got valid=%0d span=%0d %0h/%0b expected 1 span=%0d %0h/%0b",
                 k, got, span, bus.freq_o, bus.overflow_o, PERIOD, to_bcd(t), exp_ovf);
      end
    end
  endtask

  task automatic test_run_drop();
    int  w, e_idle;
    bit  got, held;
    tgt = 37;
    repeat (19) @(negedge clk);
    bus.cout_i = 1'b1;
    @(negedge clk);
    bus.cout_i = 1'b0;
    repeat (CC + 50 - 21) @(negedge clk);
    bus.run_i = 1'b0;
    wait_valid(PERIOD + 5, got, w, held);
    total++;
    if (!got || (CC + 50 + w) != PERIOD + 1) begin
      bad++;
      $display("FAIL drop_completes: got valid=%0d at %0d expected 1 at %0d", got, CC + 50 + w, PERIOD + 1);
    end
    total++;
    if (bus.freq_o !== to_bcd(37) || bus.overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL drop_result: got %0h/%0b expected %0h/1", bus.freq_o, bus.overflow_o, to_bcd(37));
    end
    total++;
    if (bus.busy_o !== 1'b0 || bus.cnt_rst_o !== 1'b0 || bus.enable_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: got busy=%0b cnt_rst=%0b en=%0b expected 0 0 0",
               bus.busy_o, bus.cnt_rst_o, bus.enable_o);
    end
    e_idle = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.cnt_rst_o !== 1'b0 || bus.valid_o !== 1'b0 ||
          bus.freq_o !== to_bcd(37)) e_idle++;
    end
    total++;
    if (e_idle != 0) begin bad++; $display("FAIL drop_stays_idle: got %0d bad cycles expected 0", e_idle); end
  endtask

  task automatic test_mid_reset();
    int  w, e_rst;
    bit  got, held;
    tgt       = 12;
    bus.run_i = 1'b1;
    repeat (CC + 30 + 1) @(negedge clk);
    total++;
    if (bus.enable_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_in_gate: got en=%0b expected 1", bus.enable_o);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.enable_o, bus.busy_o, bus.freq_o, bus.overflow_o, bus.valid_o, bus.cnt_rst_o} !== '0) begin
      bad++;
      $display("FAIL midrst_abort: got %0h expected 0",
               {bus.enable_o, bus.busy_o, bus.freq_o, bus.overflow_o, bus.valid_o, bus.cnt_rst_o});
    end
    e_rst = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.valid_o !== 1'b0) e_rst++;
    end
    total++;
    if (e_rst != 0) begin bad++; $display("FAIL midrst_hold: got %0d bad cycles expected 0", e_rst); end
    rst = 1'b1;
    wait_valid(PERIOD + 10, got, w, held);
    total++;
    if (!got || w != PERIOD + 1 || !held) begin
      bad++;
      $display("FAIL midrst_restart: got valid=%0d after %0d held=%0d expected 1 after %0d held=1",
               got, w, held, PERIOD + 1);
    end
    total++;
    if (bus.freq_o !== to_bcd(12) || bus.overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_result: got %0h/%0b expected %0h/0", bus.freq_o, bus.overflow_o, to_bcd(12));
    end
    bus.run_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_continuous();
    test_overflow();
    test_random();
    test_run_drop();
    test_mid_reset();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Measurement sequencer for the frequency meter, wrapped around the BCD decade counter chain.
- Upstream role: generates the counter's clear and gate-enable from the system clock.
- Downstream role: after the gate closes and the ripple chain settles, latches the BCD count and the overflow carry into stable system-clock-domain registers.
- Feeds the display and reporting logic with a held result plus a one-cycle valid strobe.

Parameters:
- DIG_WIDTH, 8, number of BCD digits in the counter chain; count bus width is DIG_WIDTH*4.
- GATE_CYCLES, 50000000, clk cycles the gate stays open (1 s at 50 MHz); must be >= 1.
- CLEAR_CYCLES, 4, clk cycles the counter is held cleared before each gate; must be >= 1.
- SETTLE_CYCLES, 8, clk cycles waited after the gate closes before latching; must be >= 1.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-low reset.
- run_i, input, 1, level; high requests continuous back-to-back measurements.
- count_i, input, DIG_WIDTH*4, BCD count from the counter chain; asynchronous to clk; digit 0 in bits [3:0].
- cout_i, input, 1, final carry of the counter chain; asynchronous to clk.
- cnt_rst_o, output, 1, active-low clear to the counter chain.
- enable_o, output, 1, gate enable to the counter chain.
- freq_o, output, DIG_WIDTH*4, latched BCD result.
- overflow_o, output, 1, latched overflow flag for the result in freq_o.
- valid_o, output, 1, one-cycle strobe; high on the cycle freq_o/overflow_o take a new value.
- busy_o, output, 1, high in any state other than IDLE.

Behaviour:
- Reset: while rst=0 at a clk edge:
  - state goes to IDLE and the phase counter clears.
  - cnt_rst_o=0, enable_o=0, freq_o=0, overflow_o=0, valid_o=0, busy_o=0.
  - sticky overflow flag and synchronizer flops clear.
  - Reset mid-measurement aborts immediately; no partial latch occurs.
- All outputs are registered.
- One phase counter, width $clog2 of the largest phase length plus 1. It reloads to 0 on every state change.
- States:
  - IDLE: cnt_rst_o=0 (counter held clear), enable_o=0. If run_i=1 at an edge, go to CLEAR.
  - CLEAR: cnt_rst_o=0, enable_o=0; lasts exactly CLEAR_CYCLES cycles, then GATE.
  - GATE: cnt_rst_o=1, enable_o=1; lasts exactly GATE_CYCLES cycles, then SETTLE.
  - SETTLE: cnt_rst_o=1, enable_o=0; lasts exactly SETTLE_CYCLES cycles, then LATCH.
  - LATCH: one cycle; cnt_rst_o=1, enable_o=0. At its ending edge, freq_o<=count_i and overflow_o<=sticky flag. Next state is CLEAR if run_i=1, else IDLE.
- valid_o: high for exactly the one cycle following the LATCH edge, coincident with the new freq_o.
- Output hold: freq_o and overflow_o hold their value until the next LATCH or reset.
- Back-to-back measurement period: CLEAR_CYCLES+GATE_CYCLES+SETTLE_CYCLES+1 cycles.
- Stable sampling: count_i is sampled only in LATCH. It is static there, since the gate has been closed for SETTLE_CYCLES, so no per-bit synchronizer is needed on count_i.
- Overflow detection:
  - cout_i passes through a 2-flop synchronizer; a rising edge is detected on the synchronized signal.
  - The sticky flag clears on entry to CLEAR.
  - The flag sets on a detected rising edge while in GATE or SETTLE; edges in any other state are ignored.
  - The flag only rises within a measurement; it is never cleared mid-measurement.
- run_i handling:
  - Deasserting run_i during CLEAR, GATE or SETTLE does not abort; the current measurement completes, latches, then goes to IDLE.
  - run_i is examined only in IDLE and LATCH.
- enable_o and cnt_rst_o never change in the same cycle in a way that would open the gate while the counter is cleared. GATE is always preceded by at least one CLEAR cycle.

Test Plan:
- Params DIG_WIDTH=4, GATE_CYCLES=100, CLEAR_CYCLES=4, SETTLE_CYCLES=8.
- Reset: hold rst=0 for 3 cycles with run_i=1 -> all outputs 0 and state IDLE. Release -> cnt_rst_o=0 for 4 cycles, then enable_o=1 for exactly 100 cycles, cnt_rst_o=1 from that point.
- Model counter clocked at 1/4 clk during gate, count_i settles to BCD 0x0025 -> valid_o pulses 113 cycles after the first CLEAR cycle; freq_o=16'h0025, overflow_o=0; freq_o held until the next pulse.
- Continuous run: run_i held high for 3 measurements with model counts 25, 26, 24 -> three valid_o pulses spaced exactly 113 cycles apart; freq_o sequence 0x0025, 0x0026, 0x0024.
- Overflow: cout_i rises during GATE -> overflow_o=1 at the next valid_o. Next measurement with no carry -> overflow_o=0. A cout_i pulse injected during CLEAR -> flag not set.
- run_i dropped at cycle 50 of GATE -> measurement completes, valid_o pulses, then busy_o=0 and state IDLE with cnt_rst_o=0.
- rst=0 asserted mid-GATE -> next edge: enable_o=0, busy_o=0, freq_o=0, no valid_o pulse; a fresh measurement starts after release with run_i=1.
